// File: rtl/display_scan.sv
// Two-digit multiplexed 7-segment scanner: per-frame BCD latching, anode dead-time,
// optional leading-zero blanking and whole-display blink. Outputs are registered.
module display_scan #(
    parameter int unsigned DIV       = 50000,
    parameter int unsigned GUARD     = 500,
    parameter int unsigned BLINK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] uni,
    input  logic [3:0] dec,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic {S_UNI, S_DEC} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    uni_q;
    logic [3:0]    dec_q;
    logic [BW-1:0] fcnt;
    logic          blink_off;

    logic          slot_end;
    logic          dark;
    logic [3:0]    digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    assign slot_end = (cnt == CW'(DIV - 1));

    // Both anodes are dark during the slot guard, the blink OFF phase, or a blanked leading zero.
    always_comb begin
        digit = (state == S_UNI) ? uni_q : dec_q;
        dark  = (32'(cnt) < GUARD)
             || (blink_en && blink_off)
             || ((state == S_DEC) && blank_lz && (dec_q == 4'd0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            state     <= S_UNI;
            uni_q     <= '0;
            dec_q     <= '0;
            fcnt      <= '0;
            blink_off <= 1'b0;
            seg       <= 7'h7F;
            an        <= 2'b11;
            frame     <= 1'b0;
        end else begin
            seg   <= dark ? 7'h7F : decode(digit);
            an    <= dark ? 2'b11 : ((state == S_UNI) ? 2'b10 : 2'b01);
            frame <= slot_end && (state == S_DEC);

            if (slot_end) begin
                cnt <= '0;
                case (state)
                    S_UNI: state <= S_DEC;
                    S_DEC: begin
                        state <= S_UNI;
                        uni_q <= uni;
                        dec_q <= dec;
                        if (fcnt == BW'(BLINK_DIV - 1)) begin
                            fcnt      <= '0;
                            blink_off <= ~blink_off;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                    default: state <= S_UNI;
                endcase
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: per-cycle comparison against an elapsed-cycle arithmetic model,
// plus directed literal checks of reset, tear-free latching, blanking, dash code and blink.
module tb_display_scan;

    localparam int DIV       = 4;
    localparam int GUARD     = 1;
    localparam int BLINK_DIV = 2;
    localparam int FRAME_LEN = 2 * DIV;

    logic       clk;
    logic       rst;
    logic [3:0] uni;
    logic [3:0] dec;
    logic       blank_lz;
    logic       blink_en;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame;

    int errors = 0;
    int checks = 0;

    logic [6:0] dtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    display_scan #(
        .DIV      (DIV),
        .GUARD    (GUARD),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uni     (uni),
        .dec     (dec),
        .blank_lz(blank_lz),
        .blink_en(blink_en),
        .seg     (seg),
        .an      (an),
        .frame   (frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: n = edges since reset release; everything derives from n and the latched pair.
    int         n = 0;
    logic [3:0] uq = '0;
    logic [3:0] dq = '0;

    always @(posedge clk) begin
        int m;
        bit sdec;
        bit poff;
        bit off;
        logic [6:0] es;
        logic [1:0] ea;
        logic       ef;
        if (!rst) begin
            n  = 0;
            uq = '0;
            dq = '0;
            es = 7'h7F;
            ea = 2'b11;
            ef = 1'b0;
        end else begin
            m    = n;
            sdec = ((m / DIV) % 2) == 1;
            poff = (((m / FRAME_LEN) / BLINK_DIV) % 2) == 1;
            off  = ((m % DIV) < GUARD) || (blink_en && poff) || (sdec && blank_lz && (dq == 4'd0));
            ea   = off ? 2'b11 : (sdec ? 2'b01 : 2'b10);
            es   = off ? 7'h7F : dtab[sdec ? dq : uq];
            ef   = ((m + 1) % FRAME_LEN) == 0;
            if (ef) begin
                uq = uni;
                dq = dec;
            end
            n++;
        end
        #1;
        chk("model_seg", 32'(seg), 32'(es));
        chk("model_an", 32'(an), 32'(ea));
        chk("model_frame", 32'(frame), 32'(ef));
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (frame) seen = 1'b1;
        end
        chk("frame_timeout", 32'(seen), 32'd1);
    endtask

    // Release reset with uni=3, dec=7 and pin the first frame literally.
    task automatic reset_scenario();
        @(negedge clk);
        rst = 1'b1;
        step(7);
        chk("first_frame_early", 32'(frame), 32'd0);
        step(1);
        chk("first_frame", 32'(frame), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (i == 1 || i == 5) begin
                chk("guard_an", 32'(an), 32'h3);
                chk("guard_seg", 32'(seg), 32'h7F);
            end else if (i < 5) begin
                chk("uni_an", 32'(an), 32'h2);
                chk("uni_seg", 32'(seg), 32'h30);
            end else begin
                chk("dec_an", 32'(an), 32'h1);
                chk("dec_seg", 32'(seg), 32'h78);
            end
        end
    endtask

    initial begin
        bit rec [8];
        int ones;
        bit found;

        rst      = 1'b0;
        uni      = 4'd3;
        dec      = 4'd7;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        step(3);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_an", 32'(an), 32'h3);
        chk("reset_frame", 32'(frame), 32'd0);
        reset_scenario();

        // Tear-free latching: uni changes mid S_DEC slot.
        uni = 4'd5;
        dec = 4'd1;
        wait_frame();
        step(2);
        chk("tear_old_seg", 32'(seg), 32'h12);
        step(3);
        uni = 4'd9;
        step(1);
        chk("tear_dec_seg", 32'(seg), 32'h79);
        chk("tear_dec_an", 32'(an), 32'h1);
        step(2);
        chk("tear_frame", 32'(frame), 32'd1);
        step(2);
        chk("tear_new_seg", 32'(seg), 32'h10);
        chk("tear_new_an", 32'(an), 32'h2);

        // Leading zero blanking.
        dec      = 4'd0;
        uni      = 4'd8;
        blank_lz = 1'b1;
        wait_frame();
        step(2);
        chk("lz_uni_seg", 32'(seg), 32'h00);
        step(4);
        chk("lz_dec_an", 32'(an), 32'h3);
        chk("lz_dec_seg", 32'(seg), 32'h7F);
        blank_lz = 1'b0;
        step(8);
        chk("nolz_dec_an", 32'(an), 32'h1);
        chk("nolz_dec_seg", 32'(seg), 32'h40);

        // Invalid BCD shows a dash.
        uni = 4'hC;
        wait_frame();
        step(2);
        chk("dash_seg", 32'(seg), 32'h3F);

        // Blink: two frames on, two off.
        uni      = 4'd2;
        dec      = 4'd4;
        blink_en = 1'b1;
        wait_frame();
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            wait_frame();
            step(2);
            rec[i] = (an == 2'b10);
            if (rec[i]) ones++;
        end
        chk("blink_on_frames", 32'(ones), 32'd4);
        for (int i = 0; i < 6; i++) chk("blink_period", 32'(rec[i]), 32'(!rec[i+2]));

        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            wait_frame();
            step(2);
            if (an == 2'b11) found = 1'b1;
        end
        chk("blink_off_found", 32'(found), 32'd1);
        blink_en = 1'b0;
        step(1);
        chk("blink_drop_an", 32'(an), 32'h2);
        chk("blink_drop_seg", 32'(seg), 32'h24);

        // Async reset mid-frame, no clock edge needed.
        wait_frame();
        step(5);
        #1;
        rst = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'h3);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_frame", 32'(frame), 32'd0);
        uni = 4'd3;
        dec = 4'd7;
        step(2);
        reset_scenario();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(1);
            if ($urandom_range(0, 3) == 0) uni = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) dec = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 60) == 0) blink_en = ~blink_en;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
